// File: rtl/mips_pkg.sv
// Shared store-path types: access size encodings and the buffered store entry.
package mips_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } store_entry_t;

endpackage

// File: rtl/store_fifo.sv
// In-order store buffer; flush empties it and overrides same-cycle push/pop.
module store_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  store_entry_t push_data,
  input  logic         pop,
  output store_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  store_entry_t     mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_q];

  // Pointer/count next state; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + PTR_W'(1);
      if (pop_ok)  rd_d = rd_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_ok && !flush) mem_q[wr_q] <= push_data;
    end
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: formats stores into byte lanes, flags misaligned accesses,
// and buffers aligned stores in order toward data memory.
module store_unit
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr
);

  store_entry_t      fmt_entry, head;
  logic              misaligned, accept, full, empty;
  logic              err_valid_q, err_valid_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  // Lane replication and byte enables; reserved size is always an error.
  always_comb begin
    fmt_entry      = '0;
    misaligned     = 1'b0;
    fmt_entry.addr = {req_addr[ADDR_W-1:2], 2'b00};
    case (size_e'(req_size))
      SIZE_BYTE: begin
        fmt_entry.wdata = {4{req_data[7:0]}};
        fmt_entry.be    = BE_W'(4'b0001 << req_addr[1:0]);
      end
      SIZE_HALF: begin
        fmt_entry.wdata = {2{req_data[15:0]}};
        fmt_entry.be    = req_addr[1] ? 4'b1100 : 4'b0011;
        misaligned      = req_addr[0];
      end
      SIZE_WORD: begin
        fmt_entry.wdata = req_data;
        fmt_entry.be    = 4'b1111;
        misaligned      = (req_addr[1:0] != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign accept = req_valid && req_ready;

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (accept && !misaligned),
    .push_data (fmt_entry),
    .pop       (mem_valid && mem_ready),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign req_ready = !full;
  assign mem_valid = !empty;
  assign mem_addr  = head.addr;
  assign mem_wdata = head.wdata;
  assign mem_be    = head.be;

  // Error pulse is raised even in a flush cycle; address held until the next error.
  always_comb begin
    err_valid_d = accept && misaligned;
    err_addr_d  = err_valid_d ? req_addr : err_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered store entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port flush  input  1  discard all buffered stores this cycle.
REQ-005 SHALL have port req_valid  input  1  store request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_data  input  32  register data, low bits significant.
REQ-009 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-010 SHALL have port mem_valid  output  1  store presented to data memory.
REQ-011 SHALL have port mem_ready  input  1  memory accepts store when high with mem_valid.
REQ-012 SHALL have port mem_addr  output  32  word address, bits [1:0] zero.
REQ-013 SHALL have port mem_wdata  output  32  lane-replicated write data.
REQ-014 SHALL have port mem_be  output  4  byte enables, bit i = byte lane i.
REQ-015 SHALL have port err_valid  output  1  one-cycle misaligned/illegal-store pulse.
REQ-016 SHALL have port err_addr  output  32  faulting req_addr, held until next error.

Function
REQ-017 Byte: wdata = data[7:0] replicated x4; be = 4'b0001 << addr[1:0]; never misaligned.
REQ-018 Half: wdata = data[15:0] replicated x2; be = addr[1] ? 4'b1100 : 4'b0011; misaligned if addr[0]=1.
REQ-019 Word: wdata = data; be = 4'b1111; misaligned if addr[1:0] != 0.
REQ-020 Size 11 SHALL be treated as misaligned.
REQ-021 req_ready SHALL equal (count < DEPTH); no same-cycle bypass when full, even if head dequeues.
REQ-022 Aligned handshake at edge N SHALL enqueue {addr[31:2],2'b00, wdata, be}; mem_valid high from cycle after N.
REQ-023 Misaligned handshake SHALL NOT enqueue; err_valid high exactly one cycle after acceptance, err_addr = req_addr.
REQ-024 mem_valid SHALL equal (count != 0); mem_addr/wdata/be SHALL show the head entry, stable while mem_valid && !mem_ready.
REQ-025 mem_valid && mem_ready SHALL pop head; stores leave in acceptance order.
REQ-026 Simultaneous enqueue and dequeue (not full) SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-027 flush SHALL set count to 0 next edge, with priority over same-cycle enqueue and dequeue; a misaligned request accepted in a flush cycle still raises err_valid.
REQ-028 Back-to-back errors SHALL give consecutive err_valid pulses, err_addr updated each.

Reset
REQ-029 rst_n low SHALL immediately force count 0, pointers 0, mem_valid 0, req_ready 1, err_valid 0, err_addr 0, storage 0 (so mem_addr/wdata/be read 0).
REQ-030 Reset mid-transfer SHALL drop all entries; no store completes after deassertion without a new request.

Structure
REQ-031 Shared package mips_pkg SHALL hold size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the store-entry struct {addr, wdata, be}.
REQ-032 Buffer SHALL be sub-module store_fifo (push/pop/flush, full/empty); lane formatting stays in store_unit.

Verification
REQ-033 SB addr 0x1003 data 0xAABBCCDD -> mem_addr 0x1000, wdata 0xDDDDDDDD, be 1000, mem_valid cycle after accept.
REQ-034 SH addr 0x2002 data 0x1234ABCD -> wdata 0xABCDABCD, be 1100; SH 0x2001 -> no mem_valid, err_valid 1 cycle, err_addr 0x2001.
REQ-035 mem_ready low, 3 aligned SW (DEPTH=2) -> 2 accepted, req_ready 0, third waits; mem_ready high -> ordered drain, third then enqueued.
REQ-036 Full buffer, flush plus req_valid same cycle -> count 0, mem_valid 0 next cycle, request not enqueued.
REQ-037 rst_n low while mem_valid && !mem_ready -> mem_valid 0 immediately, err_valid 0, req_ready 1.
